// File: rtl/dr_spacer_encoder.sv
// ---------------------------------------------------------------------------
// dr_spacer_encoder
//
// Purpose:
//   Converts a single-rail word stream into a dual-rail, return-to-spacer
//   stream. Each accepted word appears for exactly one DATA cycle, with
//   out_1 = word and out_0 = ~word. SPACER cycles come before and after it,
//   and in a SPACER cycle both rails carry {WIDTH{out_pol}}.
//   With SPACER_MODE=1 the spacer polarity flips after every DATA cycle.
//   Each rail then toggles exactly WIDTH bits over every spacer->data->spacer
//   pair, whatever the data.
//   A built-in switching-activity monitor reports the following, all
//   registered and aligned with the output cycle they describe:
//     - per-rail toggle counts
//     - the imbalance between the two rails
//     - the worst imbalance seen
//     - a saturating total.
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   reset         synchronous active-high reset
//   in_valid      in_data holds a word to encode
//   in_ready      block accepts in_data this cycle (SPACER state, not in reset)
//   in_data       single-rail word
//   out_1         true rail
//   out_0         complement rail
//   out_phase     1 = DATA cycle, 0 = SPACER cycle
//   out_pol       polarity of the current/last spacer (0 all-zero, 1 all-one)
//   sa_1          rail-1 bits toggled on entry to the current output
//   sa_0          rail-0 bits toggled on entry to the current output
//   sa_dif        |sa_1 - sa_0|
//   sa_dif_worst  maximum sa_dif since reset or sa_clr
//   sa_total      saturating running sum of sa_1 + sa_0
//   sa_clr        synchronous clear of sa_dif_worst and sa_total
// ---------------------------------------------------------------------------
module dr_spacer_encoder #(
  parameter  int WIDTH       = 32,
  parameter  int SPACER_MODE = 1,
  parameter  int CNT_W       = 16,
  localparam int SA_W        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_0,
  output logic             out_phase,
  output logic             out_pol,
  output logic [SA_W-1:0]  sa_1,
  output logic [SA_W-1:0]  sa_0,
  output logic [SA_W-1:0]  sa_dif,
  output logic [SA_W-1:0]  sa_dif_worst,
  output logic [CNT_W-1:0] sa_total,
  input  logic             sa_clr
);

  // Wide enough to hold total + sa_1 + sa_0 without wrapping before the
  // saturation test.
  localparam int SUM_W = ((CNT_W > SA_W + 1) ? CNT_W : SA_W + 1) + 1;
  localparam logic [CNT_W-1:0] TOTAL_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    ST_SPACER = 1'b0,
    ST_DATA   = 1'b1
  } state_t;

  // Number of set bits in a rail difference vector.
  function automatic logic [SA_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [SA_W-1:0] cnt;
    cnt = {SA_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + SA_W'(v[i]);
    end
    return cnt;
  endfunction

  state_t            r_state;
  logic [WIDTH-1:0]  r_out_1;
  logic [WIDTH-1:0]  r_out_0;
  logic              r_phase;
  logic              r_pol;
  logic [SA_W-1:0]   r_sa_1;
  logic [SA_W-1:0]   r_sa_0;
  logic [SA_W-1:0]   r_sa_dif;
  logic [SA_W-1:0]   r_worst;
  logic [CNT_W-1:0]  r_total;

  state_t            w_next_state;
  logic [WIDTH-1:0]  w_next_1;
  logic [WIDTH-1:0]  w_next_0;
  logic              w_next_pol;
  logic              w_flip_pol;
  logic [SA_W-1:0]   w_sa_1;
  logic [SA_W-1:0]   w_sa_0;
  logic [SA_W-1:0]   w_dif;
  logic [SA_W-1:0]   w_worst;
  logic [SUM_W-1:0]  w_sum;
  logic [CNT_W-1:0]  w_total;

  // The input is accepted only in a spacer cycle. The reset gate lets
  // in_ready read 0 while reset is held but 1 in the very first cycle after.
  assign in_ready = (r_state == ST_SPACER) && !reset;

  // Polarity of the spacer that follows a DATA cycle.
  assign w_flip_pol = (SPACER_MODE != 0) ? ~r_pol : 1'b0;

  // Next output words and state, before the activity monitor looks at them.
  always_comb begin
    w_next_state = r_state;
    w_next_1     = r_out_1;
    w_next_0     = r_out_0;
    w_next_pol   = r_pol;
    case (r_state)
      ST_SPACER: begin
        if (in_valid) begin
          // The word goes straight onto the rails, so it appears one cycle
          // after acceptance and needs no separate holding register.
          w_next_state = ST_DATA;
          w_next_1     = in_data;
          w_next_0     = ~in_data;
        end else begin
          w_next_state = ST_SPACER;
        end
      end
      ST_DATA: begin
        w_next_state = ST_SPACER;
        w_next_pol   = w_flip_pol;
        w_next_1     = {WIDTH{w_flip_pol}};
        w_next_0     = {WIDTH{w_flip_pol}};
      end
      default: begin
        w_next_state = ST_SPACER;
        w_next_pol   = 1'b0;
        w_next_1     = {WIDTH{1'b0}};
        w_next_0     = {WIDTH{1'b0}};
      end
    endcase
  end

  // Toggle counts for the transition into the next output word.
  always_comb begin
    w_sa_1 = popcount(w_next_1 ^ r_out_1);
    w_sa_0 = popcount(w_next_0 ^ r_out_0);
    if (w_sa_1 >= w_sa_0) begin
      w_dif = w_sa_1 - w_sa_0;
    end else begin
      w_dif = w_sa_0 - w_sa_1;
    end
  end

  // Worst-imbalance tracking and saturating total accumulation.
  always_comb begin
    if (w_dif > r_worst) begin
      w_worst = w_dif;
    end else begin
      w_worst = r_worst;
    end
    w_sum = SUM_W'(r_total) + SUM_W'(w_sa_1) + SUM_W'(w_sa_0);
    if (w_sum > SUM_W'(TOTAL_MAX)) begin
      w_total = TOTAL_MAX;
    end else begin
      w_total = w_sum[CNT_W-1:0];
    end
  end

  // State, rails and activity-monitor registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Toggles caused by reset are deliberately not counted.
      r_state  <= ST_SPACER;
      r_out_1  <= {WIDTH{1'b0}};
      r_out_0  <= {WIDTH{1'b0}};
      r_phase  <= 1'b0;
      r_pol    <= 1'b0;
      r_sa_1   <= {SA_W{1'b0}};
      r_sa_0   <= {SA_W{1'b0}};
      r_sa_dif <= {SA_W{1'b0}};
      r_worst  <= {SA_W{1'b0}};
      r_total  <= {CNT_W{1'b0}};
    end else begin
      r_state  <= w_next_state;
      r_out_1  <= w_next_1;
      r_out_0  <= w_next_0;
      r_phase  <= (w_next_state == ST_DATA);
      r_pol    <= w_next_pol;
      r_sa_1   <= w_sa_1;
      r_sa_0   <= w_sa_0;
      r_sa_dif <= w_dif;
      if (sa_clr) begin
        // The clear wins over this cycle's contribution.
        r_worst <= {SA_W{1'b0}};
        r_total <= {CNT_W{1'b0}};
      end else begin
        r_worst <= w_worst;
        r_total <= w_total;
      end
    end
  end

  assign out_1        = r_out_1;
  assign out_0        = r_out_0;
  assign out_phase    = r_phase;
  assign out_pol      = r_pol;
  assign sa_1         = r_sa_1;
  assign sa_0         = r_sa_0;
  assign sa_dif       = r_sa_dif;
  assign sa_dif_worst = r_worst;
  assign sa_total     = r_total;

endmodule
